// File: rtl/dbus_pkg.sv
// -----------------------------------------------------------------------------
// dbus_pkg
// Shared definitions for the data-side bus bridge:
//   - FSM state encoding (IDLE, ADDR, DATA, DONE, DRAIN, DRAIN_ADDR)
//   - access size codes (SZ_BYTE, SZ_HALF, SZ_WORD)
//   - store-data lane replication helper
// Optional feature macro used by the bridge: DBUS_LOADEXT_EN.
// -----------------------------------------------------------------------------
package dbus_pkg;

    typedef logic [2:0] dbus_state_t;

    localparam dbus_state_t ST_IDLE       = 3'd0;
    localparam dbus_state_t ST_ADDR       = 3'd1;
    localparam dbus_state_t ST_DATA       = 3'd2;
    localparam dbus_state_t ST_DONE       = 3'd3;
    localparam dbus_state_t ST_DRAIN      = 3'd4;
    // DRAIN sub-mode: the request was flushed before the slave accepted it,
    // so bus_req must stay up until addr_ok, then the response is drained.
    localparam dbus_state_t ST_DRAIN_ADDR = 3'd5;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Replicate right-aligned store data across all byte lanes so the slave
    // can pick the lane selected by the low address bits.
    function automatic logic [31:0] replicate_wdata(input logic [1:0]  size,
                                                    input logic [31:0] wdata);
        logic [31:0] v;
        case (size)
            SZ_BYTE: v = {4{wdata[7:0]}};
            SZ_HALF: v = {2{wdata[15:0]}};
            default: v = wdata;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/dbus_loadext.sv
// -----------------------------------------------------------------------------
// dbus_loadext
// Combinational load-data extraction: shifts the raw bus word right by the
// byte offset, truncates to the access size and sign- or zero-extends.
// Only instantiated when DBUS_LOADEXT_EN is defined.
// Ports:
//   i_rdata  [31:0] raw bus read word
//   i_offset [1:0]  byte offset (address bits [1:0])
//   i_size   [1:0]  access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   i_sign          1 = sign-extend, 0 = zero-extend
//   o_data   [31:0] extracted, extended load result
// -----------------------------------------------------------------------------
module dbus_loadext
    import dbus_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_sign,
    output logic [31:0] o_data
);

    logic [31:0] w_shifted;

    // Shift the addressed lane down to bit 0, then truncate and extend.
    always_comb begin
        w_shifted = i_rdata >> {i_offset, 3'b000};
        case (i_size)
            SZ_BYTE: o_data = {{24{i_sign & w_shifted[7]}},  w_shifted[7:0]};
            SZ_HALF: o_data = {{16{i_sign & w_shifted[15]}}, w_shifted[15:0]};
            default: o_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/dbus_bridge.sv
// -----------------------------------------------------------------------------
// dbus_bridge
// Data-side bus master for the memory stage. Turns one load/store into a
// single transaction on an SRAM-style req/addr_ok/data_ok bus, stalls the
// pipeline until it completes and survives flushes with the transaction
// still in flight (a presented request is never withdrawn, an accepted
// request always has its response drained).
//
// Optional feature: DBUS_LOADEXT_EN -- when defined, mem_rdata is the
// shifted/truncated/extended load value; otherwise the raw bus word.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   mem_en/wr/size/sign memory-stage access request (sampled in IDLE only)
//   mem_addr, mem_wdata access address and right-aligned store data
//   flush               abandon the current access
//   dbus_stall          stall request to the hazard controller
//   mem_rdata           load result, valid in the DONE cycle
//   bus_req/wr/size/addr/wdata  registered bus request outputs
//   bus_addr_ok         slave accepted the request
//   bus_data_ok         response present
//   bus_rdata           slave read data
// -----------------------------------------------------------------------------
module dbus_bridge
    import dbus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_en,
    input  logic              mem_wr,
    input  logic [1:0]        mem_size,
    input  logic              mem_sign,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              flush,
    output logic              dbus_stall,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    dbus_state_t       r_state;
    dbus_state_t       w_state_nxt;
    logic              w_capture;
    logic              w_accept;
    logic              r_bus_req;
    logic              r_bus_wr;
    logic [1:0]        r_bus_size;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_bus_wdata;
    logic [DATA_W-1:0] r_mem_rdata;
    logic [DATA_W-1:0] w_load_data;

    assign w_accept = (r_state == ST_IDLE) && mem_en && !flush;

    // Next-state logic; w_capture marks the cycle whose response is kept.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_ADDR;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (bus_addr_ok) begin
                    if (flush) begin
                        // Accepted but flushed: drop the response if it is
                        // already here, otherwise wait for it.
                        if (bus_data_ok) begin
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt = ST_DRAIN;
                        end
                    end else if (bus_data_ok) begin
                        w_state_nxt = ST_DONE;
                        w_capture   = 1'b1;
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end else if (flush) begin
                    w_state_nxt = ST_DRAIN_ADDR;
                end else begin
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (bus_data_ok) begin
                    if (flush) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_DONE;
                        w_capture   = 1'b1;
                    end
                end else if (flush) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            ST_DRAIN: begin
                if (bus_data_ok) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN_ADDR: begin
                if (bus_addr_ok) begin
                    if (bus_data_ok) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_DRAIN;
                    end
                end else begin
                    w_state_nxt = ST_DRAIN_ADDR;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // bus_req follows the next state so it falls the cycle after addr_ok.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bus_req <= 1'b0;
        end else begin
            r_bus_req <= (w_state_nxt == ST_ADDR) || (w_state_nxt == ST_DRAIN_ADDR);
        end
    end

    // Bus request fields are loaded once, when IDLE accepts an access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bus_wr    <= 1'b0;
            r_bus_size  <= 2'd0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
        end else if (w_accept) begin
            r_bus_wr    <= mem_wr;
            r_bus_size  <= mem_size;
            r_bus_addr  <= mem_addr;
            r_bus_wdata <= replicate_wdata(mem_size, mem_wdata);
        end
    end

`ifdef DBUS_LOADEXT_EN
    logic r_sign;

    // Sign-extension request travels with the rest of the access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sign <= 1'b0;
        end else if (w_accept) begin
            r_sign <= mem_sign;
        end
    end

    dbus_loadext u_loadext (
        .i_rdata  (bus_rdata),
        .i_offset (r_bus_addr[1:0]),
        .i_size   (r_bus_size),
        .i_sign   (r_sign),
        .o_data   (w_load_data)
    );
`else
    // Raw word is returned; lane extraction happens in writeback.
    logic w_unused_sign;
    assign w_unused_sign = mem_sign;
    assign w_load_data   = bus_rdata;
`endif

    // Load result register, updated only by a response that is not flushed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_rdata <= '0;
        end else if (w_capture) begin
            r_mem_rdata <= w_load_data;
        end
    end

    assign dbus_stall = mem_en && (r_state != ST_DONE);
    assign mem_rdata  = r_mem_rdata;
    assign bus_req    = r_bus_req;
    assign bus_wr     = r_bus_wr;
    assign bus_size   = r_bus_size;
    assign bus_addr   = r_bus_addr;
    assign bus_wdata  = r_bus_wdata;

endmodule
